// File: rtl/tm_program_loader.sv
// ---------------------------------------------------------------------------
// tm_program_loader
//
// Drives the Next / Done / input_data interface of a TuringMachine so that a
// host can download a transition table without buttons and switches. Host
// words are queued in a small FIFO. An FSM then presents each word on tm_data:
//   - it holds the word stable for HOLD cycles,
//   - strobes tm_next for one cycle,
//   - waits GAP idle cycles,
//   - and, after the final word of a program, strobes tm_done for one cycle.
//
// Ports
//   clock       in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   in_valid    in   1  host word valid
//   in_data     in   6  host word (transition-table entry)
//   in_last     in   1  word is the final entry of a program
//   in_ready    out  1  FIFO can accept a word (not full)
//   tm_data     out  6  word presented to TuringMachine input_data
//   tm_next     out  1  one-cycle strobe to TuringMachine Next
//   tm_done     out  1  one-cycle strobe to TuringMachine Done
//   busy        out  1  FIFO non-empty or FSM not idle
//   words_sent  out  8  tm_next strobes since the last tm_done
//
// Parameters
//   DEPTH  FIFO entries, power of two, 2..16
//   HOLD   cycles tm_data is stable before tm_next rises, 1..15
//   GAP    idle cycles after each tm_next strobe, 1..15
// ---------------------------------------------------------------------------
module tm_program_loader #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 2,
    parameter int GAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic [5:0] tm_data,
    output logic       tm_next,
    output logic       tm_done,
    output logic       busy,
    output logic [7:0] words_sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [3:0]    HOLD_LAST = 4'(HOLD - 1);
    localparam logic [3:0]    GAP_LAST  = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping; each entry is {last, data}
    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          avail_q;
    logic          push_s, pop_s, full_s, empty_s;
    logic [6:0]    head_s;

    // FSM and registered outputs
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [5:0]    tm_data_q, tm_data_d;
    logic          last_q, last_d;
    logic          tm_next_q, tm_next_d;
    logic          tm_done_q, tm_done_d;
    logic [7:0]    words_q, words_d;

    assign full_s   = (count_q == FULL_CNT);
    assign empty_s  = (count_q == CNT_ZERO);
    assign in_ready = ~full_s;
    assign push_s   = in_valid & ~full_s;
    assign head_s   = mem_q[rd_ptr_q];

    assign tm_data    = tm_data_q;
    assign tm_next    = tm_next_q;
    assign tm_done    = tm_done_q;
    assign words_sent = words_q;
    assign busy       = ~empty_s | (state_q != S_IDLE);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write port; contents are don't-care until counted as valid
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    // FSM next-state, pop request and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tm_data_d = tm_data_q;
        last_d    = last_q;
        words_d   = words_q;
        pop_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // avail_q lags the occupancy by one cycle, so a word written
                // into an empty FIFO is only popped on the following cycle.
                if (avail_q && !empty_s) begin
                    pop_s     = 1'b1;
                    tm_data_d = head_s[5:0];
                    last_d    = head_s[6];
                    cnt_d     = 4'd0;
                    state_d   = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 4'd0;
                    words_d = words_q + 8'd1;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PULSE: begin
                cnt_d   = 4'd0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = last_q ? S_DONE : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // The counter stays visible during the tm_done strobe and
                // clears at the end of it.
                words_d = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
        // Strobes come straight from flops decoded from the next state, so
        // they are glitch-free and can never be high together.
        tm_next_d = (state_d == S_PULSE);
        tm_done_d = (state_d == S_DONE);
    end

    // State, FIFO bookkeeping and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= CNT_ZERO;
            avail_q   <= 1'b0;
            cnt_q     <= 4'd0;
            tm_data_q <= 6'd0;
            last_q    <= 1'b0;
            tm_next_q <= 1'b0;
            tm_done_q <= 1'b0;
            words_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            avail_q   <= ~empty_s;
            cnt_q     <= cnt_d;
            tm_data_q <= tm_data_d;
            last_q    <= last_d;
            tm_next_q <= tm_next_d;
            tm_done_q <= tm_done_d;
            words_q   <= words_d;
        end
    end

endmodule

// File: tb/tb_tm_program_loader.sv
// ---------------------------------------------------------------------------
// Testbench for tm_program_loader. One instance uses default parameters; a
// second instance with HOLD=15 keeps its FSM parked in SETUP long enough to
// fill the FIFO. Monitors record every tm_next / tm_done strobe with its
// cycle number, and the scenario tasks compare against hand-derived values.
// ---------------------------------------------------------------------------
module tb_tm_program_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = 6'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [5:0] tm_data;
    logic       tm_next;
    logic       tm_done;
    logic       busy;
    logic [7:0] words_sent;

    logic       s_in_valid = 1'b0;
    logic [5:0] s_in_data = 6'd0;
    logic       s_in_last = 1'b0;
    logic       s_in_ready;
    logic [5:0] s_tm_data;
    logic       s_tm_next;
    logic       s_tm_done;
    logic       s_busy;
    logic [7:0] s_words_sent;

    int n_pass = 0;
    int n_total = 0;
    int edge_cnt = 0;

    // strobe records for the default instance
    logic [5:0] nx_data [256];
    int         nx_cyc  [256];
    logic [7:0] nx_ws   [256];
    int         nx_n = 0;
    int         dn_cyc  [256];
    logic [7:0] dn_ws   [256];
    int         dn_n = 0;
    int         both_cnt = 0;

    // strobe records for the slow instance
    logic [5:0] s_nx_data [256];
    int         s_nx_n = 0;
    logic [7:0] s_dn_ws   [256];
    int         s_dn_n = 0;

    tm_program_loader u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .tm_data(tm_data),
        .tm_next(tm_next), .tm_done(tm_done), .busy(busy), .words_sent(words_sent)
    );

    tm_program_loader #(.DEPTH(8), .HOLD(15), .GAP(2)) u_slow (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_last(s_in_last), .in_ready(s_in_ready), .tm_data(s_tm_data),
        .tm_next(s_tm_next), .tm_done(s_tm_done), .busy(s_busy), .words_sent(s_words_sent)
    );

    always #5 clock = ~clock;

    // cycle id: value seen between an edge and the next one
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // record strobes mid-cycle
    always @(negedge clock) begin
        if (tm_next && nx_n < 256) begin
            nx_data[nx_n] <= tm_data;
            nx_cyc[nx_n]  <= edge_cnt;
            nx_ws[nx_n]   <= words_sent;
            nx_n          <= nx_n + 1;
        end
        if (tm_done && dn_n < 256) begin
            dn_cyc[dn_n] <= edge_cnt;
            dn_ws[dn_n]  <= words_sent;
            dn_n         <= dn_n + 1;
        end
        if (tm_next && tm_done) both_cnt <= both_cnt + 1;
        if (s_tm_next && s_nx_n < 256) begin
            s_nx_data[s_nx_n] <= s_tm_data;
            s_nx_n            <= s_nx_n + 1;
        end
        if (s_tm_done && s_dn_n < 256) begin
            s_dn_ws[s_dn_n] <= s_words_sent;
            s_dn_n          <= s_dn_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // push one word into the default instance; e = edge id of acceptance
    task automatic push(input logic [5:0] d, input logic l, output int e, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 200) begin
            @(posedge clock); #1; n++;
        end
        ok = in_ready;
        @(posedge clock); #1;
        e = edge_cnt;
        in_valid = 1'b0; in_data = 6'd0; in_last = 1'b0;
    endtask

    task automatic s_push(input logic [5:0] d, input logic l, output int e, output bit ok);
        int n;
        n = 0;
        s_in_valid = 1'b1; s_in_data = d; s_in_last = l;
        while (!s_in_ready && n < 400) begin
            @(posedge clock); #1; n++;
        end
        ok = s_in_ready;
        @(posedge clock); #1;
        e = edge_cnt;
        s_in_valid = 1'b0; s_in_data = 6'd0; s_in_last = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        @(posedge clock); #1;
        while (busy && n < budget) begin
            @(posedge clock); #1; n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset(output int rel_edge);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (tm_data !== 6'h00) $display("FAIL rst_tm_data: got %h expected 00", tm_data); else n_pass++;
        n_total++; if (tm_next !== 1'b0) $display("FAIL rst_tm_next: got %b expected 0", tm_next); else n_pass++;
        n_total++; if (tm_done !== 1'b0) $display("FAIL rst_tm_done: got %b expected 0", tm_done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (words_sent !== 8'd0) $display("FAIL rst_words_sent: got %0d expected 0", words_sent); else n_pass++;
        n_total++; if (s_in_ready !== 1'b1) $display("FAIL rst_s_in_ready: got %b expected 1", s_in_ready); else n_pass++;
        reset = 1'b0;
        rel_edge = edge_cnt;
    endtask

    task automatic test_single(input int rel_edge);
        int p, nb, db;
        bit ok;
        nb = nx_n; db = dn_n;
        push(6'h2A, 1'b1, p, ok);
        n_total++; if (p !== rel_edge + 1) $display("FAIL single_first_push_edge: got %0d expected %0d", p, rel_edge + 1); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        n_total++; if (tm_data !== 6'h00) $display("FAIL single_data_c0: got %h expected 00", tm_data); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (tm_data !== 6'h00) $display("FAIL single_data_c1: got %h expected 00", tm_data); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (tm_data !== 6'h2A) $display("FAIL single_data_c2: got %h expected 2a", tm_data); else n_pass++;
        wait_idle(40, ok);
        n_total++; if (!ok) $display("FAIL single_timeout: busy still %b after budget, expected 0", busy); else n_pass++;
        n_total++; if (nx_n - nb !== 1) $display("FAIL single_next_count: got %0d expected 1", nx_n - nb); else n_pass++;
        n_total++; if (nx_cyc[nb] !== p + 4) $display("FAIL single_next_cycle: got %0d expected %0d", nx_cyc[nb], p + 4); else n_pass++;
        n_total++; if (nx_data[nb] !== 6'h2A) $display("FAIL single_next_data: got %h expected 2a", nx_data[nb]); else n_pass++;
        n_total++; if (nx_ws[nb] !== 8'd1) $display("FAIL single_ws_at_next: got %0d expected 1", nx_ws[nb]); else n_pass++;
        n_total++; if (dn_n - db !== 1) $display("FAIL single_done_count: got %0d expected 1", dn_n - db); else n_pass++;
        n_total++; if (dn_cyc[db] !== p + 7) $display("FAIL single_done_cycle: got %0d expected %0d", dn_cyc[db], p + 7); else n_pass++;
        n_total++; if (dn_ws[db] !== 8'd1) $display("FAIL single_ws_at_done: got %0d expected 1", dn_ws[db]); else n_pass++;
        n_total++; if (words_sent !== 8'd0) $display("FAIL single_ws_after: got %0d expected 0", words_sent); else n_pass++;
        n_total++; if (tm_data !== 6'h2A) $display("FAIL single_data_hold: got %h expected 2a", tm_data); else n_pass++;
    endtask

    task automatic test_fill();
        int e0, e, nb, db, n;
        bit ok;
        nb = s_nx_n; db = s_dn_n;
        e0 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                n_total++; if (s_in_ready !== 1'b1) $display("FAIL fill_ready_before_9th: got %b expected 1", s_in_ready); else n_pass++;
            end
            s_push(6'h20 + 6'(i), (i == 8), e, ok);
            if (i == 0) e0 = e;
            n_total++; if (e !== e0 + i) $display("FAIL fill_push_edge_%0d: got %0d expected %0d", i, e, e0 + i); else n_pass++;
        end
        n_total++; if (s_in_ready !== 1'b0) $display("FAIL fill_ready_full: got %b expected 0", s_in_ready); else n_pass++;
        // offer a junk word while full; it must be ignored
        s_in_valid = 1'b1; s_in_data = 6'h3F; s_in_last = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        s_in_valid = 1'b0; s_in_data = 6'd0; s_in_last = 1'b0;
        n_total++; if (s_in_ready !== 1'b0) $display("FAIL fill_ready_still_full: got %b expected 0", s_in_ready); else n_pass++;
        n = 0;
        @(posedge clock); #1;
        while (s_busy && n < 400) begin @(posedge clock); #1; n++; end
        n_total++; if (s_busy !== 1'b0) $display("FAIL fill_timeout: busy %b expected 0", s_busy); else n_pass++;
        n_total++; if (s_nx_n - nb !== 9) $display("FAIL fill_next_count: got %0d expected 9", s_nx_n - nb); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++; if (s_nx_data[nb + i] !== 6'h20 + 6'(i)) $display("FAIL fill_order_%0d: got %h expected %h", i, s_nx_data[nb + i], 6'h20 + 6'(i)); else n_pass++;
        end
        n_total++; if (s_dn_n - db !== 1) $display("FAIL fill_done_count: got %0d expected 1", s_dn_n - db); else n_pass++;
        n_total++; if (s_dn_ws[db] !== 8'd9) $display("FAIL fill_ws_at_done: got %0d expected 9", s_dn_ws[db]); else n_pass++;
    endtask

    task automatic test_stream();
        int e, nb, db, bad;
        bit ok;
        nb = nx_n; db = dn_n; bad = 0;
        for (int i = 0; i < 20; i++) begin
            push(6'(i), (i == 19), e, ok);
            if (!ok) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL stream_push_stall: got %0d stalled pushes expected 0", bad); else n_pass++;
        wait_idle(300, ok);
        n_total++; if (!ok) $display("FAIL stream_timeout: busy %b expected 0", busy); else n_pass++;
        n_total++; if (nx_n - nb !== 20) $display("FAIL stream_next_count: got %0d expected 20", nx_n - nb); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_total++; if (nx_data[nb + i] !== 6'(i)) $display("FAIL stream_data_%0d: got %h expected %h", i, nx_data[nb + i], 6'(i)); else n_pass++;
            n_total++; if (nx_ws[nb + i] !== 8'(i + 1)) $display("FAIL stream_ws_%0d: got %0d expected %0d", i, nx_ws[nb + i], i + 1); else n_pass++;
            if (i > 0) begin
                n_total++; if (nx_cyc[nb + i] - nx_cyc[nb + i - 1] !== 6) $display("FAIL stream_spacing_%0d: got %0d expected 6", i, nx_cyc[nb + i] - nx_cyc[nb + i - 1]); else n_pass++;
            end
        end
        n_total++; if (dn_n - db !== 1) $display("FAIL stream_done_count: got %0d expected 1", dn_n - db); else n_pass++;
        n_total++; if (dn_ws[db] !== 8'd20) $display("FAIL stream_ws_at_done: got %0d expected 20", dn_ws[db]); else n_pass++;
        n_total++; if (dn_cyc[db] !== nx_cyc[nb + 19] + 3) $display("FAIL stream_done_cycle: got %0d expected %0d", dn_cyc[db], nx_cyc[nb + 19] + 3); else n_pass++;
    endtask

    task automatic test_push_pop();
        int pa, pb, pc, pd, pe, nb, db;
        bit ok;
        logic [5:0] exp_d [5];
        exp_d[0] = 6'h31; exp_d[1] = 6'h32; exp_d[2] = 6'h33; exp_d[3] = 6'h34; exp_d[4] = 6'h35;
        nb = nx_n; db = dn_n;
        push(exp_d[0], 1'b0, pa, ok);
        repeat (2) begin @(posedge clock); #1; end
        push(exp_d[1], 1'b0, pb, ok);
        push(exp_d[2], 1'b0, pc, ok);
        push(exp_d[3], 1'b0, pd, ok);
        repeat (2) begin @(posedge clock); #1; end
        // FIFO holds 3 here; this push lands on the same edge as the pop of B
        push(exp_d[4], 1'b1, pe, ok);
        n_total++; if (pe !== pa + 8) $display("FAIL pp_push_edge: got %0d expected %0d", pe, pa + 8); else n_pass++;
        n_total++; if (tm_data !== exp_d[1]) $display("FAIL pp_pop_same_edge: got %h expected %h", tm_data, exp_d[1]); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL pp_ready: got %b expected 1", in_ready); else n_pass++;
        wait_idle(200, ok);
        n_total++; if (!ok) $display("FAIL pp_timeout: busy %b expected 0", busy); else n_pass++;
        n_total++; if (nx_n - nb !== 5) $display("FAIL pp_next_count: got %0d expected 5", nx_n - nb); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (nx_data[nb + i] !== exp_d[i]) $display("FAIL pp_order_%0d: got %h expected %h", i, nx_data[nb + i], exp_d[i]); else n_pass++;
        end
        n_total++; if (dn_n - db !== 1) $display("FAIL pp_done_count: got %0d expected 1", dn_n - db); else n_pass++;
        n_total++; if (dn_ws[db] !== 8'd5) $display("FAIL pp_ws_at_done: got %0d expected 5", dn_ws[db]); else n_pass++;
    endtask

    task automatic test_reset_pulse();
        int p, n, nb, db;
        bit ok;
        push(6'h07, 1'b1, p, ok);
        n = 0;
        while (!tm_next && n < 20) begin @(posedge clock); #1; n++; end
        n_total++; if (tm_next !== 1'b1) $display("FAIL rp_reach_pulse: got %b expected 1", tm_next); else n_pass++;
        n_total++; if (words_sent !== 8'd1) $display("FAIL rp_ws_in_pulse: got %0d expected 1", words_sent); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (tm_next !== 1'b0) $display("FAIL rp_next_async: got %b expected 0", tm_next); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rp_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (words_sent !== 8'd0) $display("FAIL rp_ws: got %0d expected 0", words_sent); else n_pass++;
        n_total++; if (tm_data !== 6'h00) $display("FAIL rp_tm_data: got %h expected 00", tm_data); else n_pass++;
        nb = nx_n; db = dn_n;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        repeat (15) begin @(posedge clock); #1; end
        n_total++; if (nx_n !== nb) $display("FAIL rp_no_next: got %0d strobes expected 0", nx_n - nb); else n_pass++;
        n_total++; if (dn_n !== db) $display("FAIL rp_no_done: got %0d strobes expected 0", dn_n - db); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rp_busy_after: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_two_programs();
        int e, nb, db;
        bit ok;
        logic [7:0] exp_ws [5];
        exp_ws[0] = 8'd1; exp_ws[1] = 8'd2; exp_ws[2] = 8'd3; exp_ws[3] = 8'd1; exp_ws[4] = 8'd2;
        nb = nx_n; db = dn_n;
        push(6'h01, 1'b0, e, ok);
        push(6'h02, 1'b0, e, ok);
        push(6'h03, 1'b1, e, ok);
        push(6'h04, 1'b0, e, ok);
        push(6'h05, 1'b1, e, ok);
        wait_idle(200, ok);
        n_total++; if (!ok) $display("FAIL two_timeout: busy %b expected 0", busy); else n_pass++;
        n_total++; if (nx_n - nb !== 5) $display("FAIL two_next_count: got %0d expected 5", nx_n - nb); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (nx_data[nb + i] !== 6'(i + 1)) $display("FAIL two_data_%0d: got %h expected %h", i, nx_data[nb + i], 6'(i + 1)); else n_pass++;
            n_total++; if (nx_ws[nb + i] !== exp_ws[i]) $display("FAIL two_ws_%0d: got %0d expected %0d", i, nx_ws[nb + i], exp_ws[i]); else n_pass++;
        end
        n_total++; if (dn_n - db !== 2) $display("FAIL two_done_count: got %0d expected 2", dn_n - db); else n_pass++;
        n_total++; if (dn_ws[db] !== 8'd3) $display("FAIL two_ws_done0: got %0d expected 3", dn_ws[db]); else n_pass++;
        n_total++; if (dn_ws[db + 1] !== 8'd2) $display("FAIL two_ws_done1: got %0d expected 2", dn_ws[db + 1]); else n_pass++;
        n_total++; if (words_sent !== 8'd0) $display("FAIL two_ws_after: got %0d expected 0", words_sent); else n_pass++;
        n_total++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); else n_pass++;
    endtask

    initial begin
        int rel;
        test_reset(rel);
        test_single(rel);
        test_fill();
        test_stream();
        test_push_pop();
        test_reset_pulse();
        test_two_programs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
